// File: rtl/mcu_sequencer_pkg.sv
// Shared constants, FSM state encodings and frame configuration record for mcu_sequencer.
package mcu_sequencer_pkg;

  localparam int CH      = 3;
  localparam int MAX_BPC = 4;
  localparam int MCUW    = 16;
  localparam int BPCW    = $clog2(MAX_BPC + 1);
  localparam int CHW     = $clog2(CH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_PAD  = 2'd3;

  // bpc is packed with component 0 in the least significant field
  typedef struct packed {
    logic [CH*BPCW-1:0] bpc;
    logic [MCUW-1:0]    mcu_total;
    logic [MCUW-1:0]    rst_int;
  } cfg_t;

endpackage

// File: rtl/mcu_sequencer_walk.sv
// Component/block/MCU walker: tracks where the current block sits in the frame.
// Restart-interval counting exists only when MCU_SEQ_RESTART_EN is defined.
module mcu_sequencer_walk
  import mcu_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  cfg_t           cfg,
  input  logic           frame_start,
  input  logic           clr,
  input  logic           step,
`ifdef MCU_SEQ_RESTART_EN
  input  logic           mark,
`endif
  output logic [CHW-1:0] ch,
  output logic           frame_end,
  output logic           restart_due
);

  logic [CHW-1:0]  ch_q, ch_d;
  logic [BPCW-1:0] blk_q, blk_d;
  logic [MCUW-1:0] mcu_q, mcu_d;
  logic [MCUW-1:0] mcu_inc;
  logic [CH-1:0]   nz;
  logic [CHW-1:0]  first_ch, next_ch;
  logic            has_next;
  logic [BPCW-1:0] cur_bpc;
  logic            last_blk;
  logic            mcu_end;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_nz
      assign nz[gi] = |cfg.bpc[gi*BPCW +: BPCW];
    end
  endgenerate

  // Descending scan so the lowest matching component is the one that sticks
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    cur_bpc  = '0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (nz[c]) first_ch = CHW'(c);
      if (nz[c] && (c > int'(ch_q))) begin
        next_ch  = CHW'(c);
        has_next = 1'b1;
      end
      if (ch_q == CHW'(c)) cur_bpc = cfg.bpc[c*BPCW +: BPCW];
    end
  end

  assign last_blk  = (blk_q == cur_bpc - BPCW'(1));
  assign mcu_end   = last_blk && !has_next;
  assign mcu_inc   = mcu_q + MCUW'(1);
  assign frame_end = mcu_end && (mcu_inc == cfg.mcu_total);
  assign ch        = ch_q;

`ifdef MCU_SEQ_RESTART_EN
  logic [MCUW-1:0] rcnt_q, rcnt_d;
  logic [MCUW-1:0] rcnt_inc;

  // Counting MCUs since the last clear is equivalent to mcu_count % rst_int
  assign rcnt_inc    = rcnt_q + MCUW'(1);
  assign restart_due = mcu_end && !frame_end && (cfg.rst_int != '0) && (rcnt_inc == cfg.rst_int);
`else
  logic unused_rst_int;
  assign unused_rst_int = ^cfg.rst_int;
  assign restart_due    = 1'b0;
`endif

  always_comb begin
    ch_d  = ch_q;
    blk_d = blk_q;
    mcu_d = mcu_q;
`ifdef MCU_SEQ_RESTART_EN
    rcnt_d = rcnt_q;
    if (frame_start) rcnt_d = '0;
`endif
    if (frame_start) mcu_d = '0;
    if (clr) begin
      ch_d  = first_ch;
      blk_d = '0;
    end else if (step) begin
      if (!last_blk) begin
        blk_d = blk_q + BPCW'(1);
      end else begin
        blk_d = '0;
        if (has_next) begin
          ch_d = next_ch;
        end else begin
          ch_d  = first_ch;
          mcu_d = mcu_inc;
`ifdef MCU_SEQ_RESTART_EN
          rcnt_d = restart_due ? '0 : rcnt_inc;
`endif
        end
      end
    end
`ifdef MCU_SEQ_RESTART_EN
    if (mark) rcnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q  <= '0;
      blk_q <= '0;
      mcu_q <= '0;
`ifdef MCU_SEQ_RESTART_EN
      rcnt_q <= '0;
`endif
    end else begin
      ch_q  <= ch_d;
      blk_q <= blk_d;
      mcu_q <= mcu_d;
`ifdef MCU_SEQ_RESTART_EN
      rcnt_q <= rcnt_d;
`endif
    end
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Attaches component/DC-AC context to decoded coefficients, pads after EOB, clears predictors.
// Optional MCU_SEQ_RESTART_EN adds restart-interval clearing and the in_rst_marker input.
module mcu_sequencer
  import mcu_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [CH*BPCW-1:0] cfg_bpc,
  input  logic [MCUW-1:0]    cfg_mcu_total,
  input  logic [MCUW-1:0]    cfg_rst_int,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [11:0] in_coef,
  input  logic               in_eob,
`ifdef MCU_SEQ_RESTART_EN
  input  logic               in_rst_marker,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [11:0] out_coef,
  output logic               out_freq,
  output logic [CHW-1:0]     out_ch,
  output logic [5:0]         out_idx,
  output logic               out_last,
  output logic               pred_clr,
  output logic               frame_done
);

  logic [1:0]         state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  cfg_t               cfg_q, cfg_d;
  logic               out_valid_q, out_valid_d;
  logic signed [11:0] out_coef_q, out_coef_d;
  logic               out_freq_q, out_freq_d;
  logic [CHW-1:0]     out_ch_q, out_ch_d;
  logic [5:0]         out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;
  logic               out_fe_q, out_fe_d;
  logic               frame_done_q, frame_done_d;

  logic               out_free, accept, pad_emit, emit, idx_end, blk_end;
  logic               marker_hit, degenerate;
  logic [CHW-1:0]     walk_ch;
  logic               walk_frame_end, walk_restart_due;

`ifdef MCU_SEQ_RESTART_EN
  assign marker_hit = (state_q == ST_RUN) && (idx_q == 6'd0) && in_rst_marker;
`else
  assign marker_hit = 1'b0;
`endif

  assign out_free   = !out_valid_q || out_ready;
  assign in_ready   = (state_q == ST_RUN) && out_free && !marker_hit;
  assign accept     = in_valid && in_ready;
  assign pad_emit   = (state_q == ST_PAD) && out_free;
  assign emit       = accept || pad_emit;
  assign idx_end    = (idx_q == 6'd63);
  assign blk_end    = emit && idx_end;
  assign degenerate = (cfg_bpc == '0) || (cfg_mcu_total == '0);

  mcu_sequencer_walk u_walk (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_q),
    .frame_start (state_q == ST_IDLE),
    .clr         (state_q == ST_CLR),
    .step        (blk_end),
`ifdef MCU_SEQ_RESTART_EN
    .mark        (marker_hit),
`endif
    .ch          (walk_ch),
    .frame_end   (walk_frame_end),
    .restart_due (walk_restart_due)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cfg_d        = cfg_q;
    out_valid_d  = out_valid_q;
    out_coef_d   = out_coef_q;
    out_freq_d   = out_freq_q;
    out_ch_d     = out_ch_q;
    out_idx_d    = out_idx_q;
    out_last_d   = out_last_q;
    out_fe_d     = out_fe_q;
    frame_done_d = 1'b0;

    // frame_done follows the handshake of the coefficient tagged as the frame's last
    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      out_fe_d     = 1'b0;
      frame_done_d = out_fe_q;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_coef_d  = accept ? in_coef : 12'sd0;
      out_freq_d  = (idx_q != 6'd0);
      out_ch_d    = walk_ch;
      out_idx_d   = idx_q;
      out_last_d  = idx_end;
      out_fe_d    = blk_end && walk_frame_end;
      idx_d       = idx_q + 6'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          cfg_d = '{bpc: cfg_bpc, mcu_total: cfg_mcu_total, rst_int: cfg_rst_int};
          if (degenerate) frame_done_d = 1'b1;
          else            state_d      = ST_CLR;
        end
      end
      ST_CLR: begin
        idx_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (marker_hit)                     state_d = ST_CLR;
        else if (accept && !idx_end && in_eob) state_d = ST_PAD;
      end
      default: ;
    endcase

    if (blk_end) begin
      if (walk_frame_end)        state_d = ST_IDLE;
      else if (walk_restart_due) state_d = ST_CLR;
      else                       state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cfg_q        <= '0;
      out_valid_q  <= 1'b0;
      out_coef_q   <= '0;
      out_freq_q   <= 1'b0;
      out_ch_q     <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      out_fe_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cfg_q        <= cfg_d;
      out_valid_q  <= out_valid_d;
      out_coef_q   <= out_coef_d;
      out_freq_q   <= out_freq_d;
      out_ch_q     <= out_ch_d;
      out_idx_q    <= out_idx_d;
      out_last_q   <= out_last_d;
      out_fe_q     <= out_fe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_coef   = out_coef_q;
  assign out_freq   = out_freq_q;
  assign out_ch     = out_ch_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign pred_clr   = (state_q == ST_CLR);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: frame table plus hand-written DC-only and mid-frame reset cases.
module tb_mcu_sequencer;
  import mcu_sequencer_pkg::*;

`ifdef MCU_SEQ_RESTART_EN
  localparam int RE = 1;
`else
  localparam int RE = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic [CH*BPCW-1:0] cfg_bpc = '0;
  logic [MCUW-1:0]    cfg_mcu_total = '0;
  logic [MCUW-1:0]    cfg_rst_int = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] in_coef = '0;
  logic               in_eob = 1'b0;
  logic               in_rst_marker = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [11:0] out_coef;
  logic               out_freq;
  logic [CHW-1:0]     out_ch;
  logic [5:0]         out_idx;
  logic               out_last;
  logic               pred_clr;
  logic               frame_done;

  mcu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_bpc       (cfg_bpc),
    .cfg_mcu_total (cfg_mcu_total),
    .cfg_rst_int   (cfg_rst_int),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_coef       (in_coef),
    .in_eob        (in_eob),
`ifdef MCU_SEQ_RESTART_EN
    .in_rst_marker (in_rst_marker),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_coef      (out_coef),
    .out_freq      (out_freq),
    .out_ch        (out_ch),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .pred_clr      (pred_clr),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [11:0] coef;
    logic               freq;
    logic [CHW-1:0]     ch;
    logic [5:0]         idx;
    logic               last;
  } exp_t;

  typedef struct {
    int b0, b1, b2;
    int total, rst_int, eob_sel, bp_mode, inject;
    int exp_outs, exp_pred;
  } vec_t;

  exp_t sb[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   bp_mode   = 0;
  bit   mon_en    = 1'b0;
  int   out_cnt, pred_cnt, done_cnt, done_at;

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act != req) begin
      bad_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Backpressure pattern applied just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'(($urandom_range(0, 1)));
      endcase
    end
  end

  // Output monitor: a handshake is visible here and completes at the next rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (pred_clr) pred_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_at = out_cnt;
      end
      if (out_valid && out_ready) begin
        exp_t e;
        out_cnt++;
        total_cnt++;
        if (sb.size() == 0) begin
          bad_cnt++;
          $display("FAIL unexpected_out #%0d: got coef=%0d ch=%0d idx=%0d, expected no output", out_cnt, out_coef, out_ch, out_idx);
        end else begin
          e = sb.pop_front();
          if ({out_coef, out_freq, out_ch, out_idx, out_last} != e) begin
            bad_cnt++;
            $display("FAIL out #%0d: got coef=%0d freq=%0b ch=%0d idx=%0d last=%0b, expected coef=%0d freq=%0b ch=%0d idx=%0d last=%0b",
                     out_cnt, out_coef, out_freq, out_ch, out_idx, out_last, e.coef, e.freq, e.ch, e.idx, e.last);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int eob_of(input int sel, input int k);
    if (sel == 0) return -1;
    if (sel == 1) return 0;
    case (k % 6)
      0: return 0;
      1: return 5;
      2: return 63;
      3: return -1;
      4: return 62;
      default: return 31;
    endcase
  endfunction

  // Called at a falling edge; returns at a falling edge after the handshake
  task automatic feed(input logic signed [11:0] v, input bit eob, input int idx, input int c, output bit ok);
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1;
    in_coef  = v;
    in_eob   = eob;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        e = '{coef: v, freq: (idx != 0), ch: CHW'(c), idx: 6'(idx), last: (idx == 63)};
        sb.push_back(e);
        if (eob) begin
          for (int p = idx + 1; p < 64; p++) begin
            e = '{coef: 12'sd0, freq: 1'b1, ch: CHW'(c), idx: 6'(p), last: (p == 63)};
            sb.push_back(e);
          end
        end
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_eob   = 1'b0;
    if (!ok) check("in_handshake_timeout", 0, 1);
  endtask

  task automatic send_cfg(input int b0, input int b1, input int b2, input int total, input int ri);
    @(negedge clk);
    cfg_valid     = 1'b1;
    cfg_bpc       = {BPCW'(b2), BPCW'(b1), BPCW'(b0)};
    cfg_mcu_total = MCUW'(total);
    cfg_rst_int   = MCUW'(ri);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic start_frame(input int mode);
    sb.delete();
    out_cnt  = 0;
    pred_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    bp_mode  = mode;
    mon_en   = 1'b1;
  endtask

  task automatic finish_frame(input string name, input int exp_outs, input int exp_pred);
    for (int t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({name, ".outputs"}, out_cnt, exp_outs);
    check({name, ".pred_clr"}, pred_cnt, exp_pred);
    check({name, ".frame_done"}, done_cnt, 1);
    check({name, ".done_after"}, done_at, exp_outs);
    check({name, ".sb_left"}, sb.size(), 0);
    mon_en = 1'b0;
    $display("%s: outputs=%0d pred_clr=%0d frame_done=%0d", name, out_cnt, pred_cnt, done_cnt);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int b[3];
    int k;
    int e;
    int last;
    bit ok;
    b[0] = v.b0; b[1] = v.b1; b[2] = v.b2;
    start_frame(v.bp_mode);
    send_cfg(v.b0, v.b1, v.b2, v.total, v.rst_int);
    k  = 0;
    ok = 1'b1;
    for (int m = 0; m < v.total && ok; m++) begin
      for (int c = 0; c < 3 && ok; c++) begin
        for (int bl = 0; bl < b[c] && ok; bl++) begin
          if (v.inject != 0 && k == 2) send_cfg(0, 0, 0, 1, 0);
          e    = eob_of(v.eob_sel, k);
          last = (e < 0) ? 63 : e;
          k++;
          for (int i = 0; i <= last && ok; i++)
            feed(12'($urandom_range(0, 4095)), (i == e), i, c, ok);
        end
      end
    end
    finish_frame(name, v.exp_outs, v.exp_pred);
  endtask

  vec_t vecs[8];

  initial begin
    bit ok;
    int hi_cnt;

    vecs[0] = '{b0:4, b1:1, b2:1, total:2, rst_int:0, eob_sel:0, bp_mode:0, inject:1, exp_outs:768, exp_pred:1};
    vecs[1] = '{b0:1, b1:1, b2:1, total:1, rst_int:0, eob_sel:1, bp_mode:0, inject:0, exp_outs:192, exp_pred:1};
    vecs[2] = '{b0:1, b1:1, b2:1, total:3, rst_int:1, eob_sel:2, bp_mode:0, inject:0, exp_outs:576, exp_pred:(RE != 0) ? 3 : 1};
    vecs[3] = '{b0:2, b1:1, b2:1, total:1, rst_int:0, eob_sel:2, bp_mode:1, inject:0, exp_outs:256, exp_pred:1};
    vecs[4] = '{b0:0, b1:2, b2:0, total:1, rst_int:0, eob_sel:2, bp_mode:2, inject:0, exp_outs:128, exp_pred:1};
    vecs[5] = '{b0:1, b1:1, b2:1, total:0, rst_int:0, eob_sel:0, bp_mode:0, inject:0, exp_outs:0,   exp_pred:0};
    vecs[6] = '{b0:0, b1:0, b2:0, total:5, rst_int:0, eob_sel:0, bp_mode:0, inject:0, exp_outs:0,   exp_pred:0};
    vecs[7] = '{b0:1, b1:1, b2:1, total:4, rst_int:2, eob_sel:1, bp_mode:2, inject:0, exp_outs:768, exp_pred:(RE != 0) ? 2 : 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.in_ready", int'(in_ready), 0);
    check("reset.pred_clr", int'(pred_clr), 0);
    check("reset.frame_done", int'(frame_done), 0);
    check("reset.out_coef", int'(out_coef), 0);
    check("reset.out_idx", int'(out_idx), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // DC-only block: one coefficient then 63 padded zeros with input stalled
    start_frame(0);
    send_cfg(1, 0, 0, 1, 0);
    feed(12'sd5, 1'b1, 0, 0, ok);
    hi_cnt = 0;
    in_valid = 1'b1;
    in_coef  = 12'sd7;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (in_ready) hi_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("dc_only.in_ready_during_pad", hi_cnt, 0);
    finish_frame("dc_only", 64, 1);

    // Reset after 100 coefficients of a 4:2:0 frame, then a clean restart
    start_frame(0);
    send_cfg(4, 1, 1, 2, 0);
    for (int i = 0; i < 100 && ok; i++) feed(12'(i + 1), 1'b0, i % 64, 0, ok);
    mon_en = 1'b0;
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset.out_valid", int'(out_valid), 0);
    check("midreset.in_ready", int'(in_ready), 0);
    check("midreset.pred_clr", int'(pred_clr), 0);
    check("midreset.frame_done", int'(frame_done), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec("after_reset", '{b0:1, b1:1, b2:1, total:1, rst_int:0, eob_sel:2, bp_mode:0, inject:0, exp_outs:192, exp_pred:1});

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
